// File: rtl/panda_pipeline_ctrl.sv
// Pipeline hazard arbiter for the Panda 5-stage core: stall/bubble priority,
// data-bus transaction FSM with timeout trap, and performance counters.
module panda_pipeline_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_use_hazard_i,
   input  logic             branch_taken_i,
   input  logic             instr_rvalid_i,
   input  logic             ex_busy_i,
   input  logic             data_req_i,
   input  logic             data_gnt_i,
   input  logic             data_rvalid_i,
   input  logic             retire_i,
   input  logic             cnt_clr_i,
   output logic             stall_if_o,
   output logic             stall_id_o,
   output logic             stall_ex_o,
   output logic             stall_mem_o,
   output logic             bubble_if_o,
   output logic             bubble_id_o,
   output logic             bubble_ex_o,
   output logic             bubble_wb_o,
   output logic             data_err_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID,
      ERROR
   } data_state_e;

   // The wait counter can reach TIMEOUT when a grant lands on the last allowed cycle.
   localparam int                TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]     T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]     T_ONE    = TW'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   data_state_e      state_q, state_d;
   logic [TW-1:0]    wait_cnt_q;
   logic             waiting;
   logic             timeout_hit;
   logic             mem_stall;
   logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q, stall_cnt_q;

   assign waiting     = (state_q == WAIT_GNT) || (state_q == WAIT_RVALID);
   assign timeout_hit = (wait_cnt_q >= T_LAST);

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_stall = data_req_i;
            if (data_req_i) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
         end
         WAIT_GNT: begin
            mem_stall = 1'b1;
            if (data_gnt_i)       state_d = WAIT_RVALID;
            else if (timeout_hit) state_d = ERROR;
         end
         WAIT_RVALID: begin
            // The response cycle releases the stall so MEM/WB captures the load data.
            mem_stall = !data_rvalid_i;
            if (data_rvalid_i)    state_d = IDLE;
            else if (timeout_hit) state_d = ERROR;
         end
         ERROR: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d   = ERROR;
            mem_stall = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) wait_cnt_q <= '0;
         else if (waiting)    wait_cnt_q <= wait_cnt_q + T_ONE;
      end
   end

   assign data_err_o = (state_q == ERROR);

   // A branch seen under a stall stays asserted by the frozen EX stage, so it wins later exactly once.
   always_comb begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      bubble_if_o = 1'b0;
      bubble_id_o = 1'b0;
      bubble_ex_o = 1'b0;
      bubble_wb_o = 1'b0;
      if (mem_stall) begin
         stall_if_o  = 1'b1;
         stall_id_o  = 1'b1;
         stall_ex_o  = 1'b1;
         stall_mem_o = 1'b1;
         bubble_wb_o = 1'b1;
      end else if (ex_busy_i) begin
         stall_if_o  = 1'b1;
         stall_id_o  = 1'b1;
         stall_ex_o  = 1'b1;
         bubble_ex_o = 1'b1;
      end else if (branch_taken_i) begin
         bubble_if_o = 1'b1;
         bubble_id_o = 1'b1;
      end else if (load_use_hazard_i) begin
         stall_if_o  = 1'b1;
         bubble_id_o = 1'b1;
      end else if (!instr_rvalid_i) begin
         stall_if_o  = 1'b1;
         bubble_if_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else if (cnt_clr_i) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
         if (retire_i)   instret_cnt_q <= instret_cnt_q + CNT_ONE;
         if (stall_if_o) stall_cnt_q   <= stall_cnt_q + CNT_ONE;
      end
   end

   assign cycle_cnt_o   = cycle_cnt_q;
   assign instret_cnt_o = instret_cnt_q;
   assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_panda_pipeline_ctrl.sv
// Directed scoreboard bench for panda_pipeline_ctrl (CNT_W=4, TIMEOUT=4).
module tb_panda_pipeline_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;

   // {stall_if, stall_id, stall_ex, stall_mem, bubble_if, bubble_id, bubble_ex, bubble_wb}
   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_MEM  = 8'b1111_0001;
   localparam logic [7:0] C_EX   = 8'b1110_0010;
   localparam logic [7:0] C_BR   = 8'b0000_1100;
   localparam logic [7:0] C_LU   = 8'b1000_0100;
   localparam logic [7:0] C_IF   = 8'b1000_1000;

   typedef struct {
      string      name;
      logic [7:0] ctl;
      logic       err;
      logic       chk_cnt;
      logic [3:0] cyc;
      logic [3:0] ins;
      logic [3:0] stl;
   } exp_t;

   logic clk, rst_n;
   logic load_use_hazard, branch_taken, instr_rvalid, ex_busy;
   logic data_req, data_gnt, data_rvalid, retire, cnt_clr;
   logic stall_if, stall_id, stall_ex, stall_mem;
   logic bubble_if, bubble_id, bubble_ex, bubble_wb, data_err;
   logic [CNT_W-1:0] cycle_cnt, instret_cnt, stall_cnt;

   exp_t sb_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   panda_pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .load_use_hazard_i(load_use_hazard),
      .branch_taken_i   (branch_taken),
      .instr_rvalid_i   (instr_rvalid),
      .ex_busy_i        (ex_busy),
      .data_req_i       (data_req),
      .data_gnt_i       (data_gnt),
      .data_rvalid_i    (data_rvalid),
      .retire_i         (retire),
      .cnt_clr_i        (cnt_clr),
      .stall_if_o       (stall_if),
      .stall_id_o       (stall_id),
      .stall_ex_o       (stall_ex),
      .stall_mem_o      (stall_mem),
      .bubble_if_o      (bubble_if),
      .bubble_id_o      (bubble_id),
      .bubble_ex_o      (bubble_ex),
      .bubble_wb_o      (bubble_wb),
      .data_err_o       (data_err),
      .cycle_cnt_o      (cycle_cnt),
      .instret_cnt_o    (instret_cnt),
      .stall_cnt_o      (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, one scoreboard entry per stimulated cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.name, ".ctl"}, {stall_if, stall_id, stall_ex, stall_mem,
                                  bubble_if, bubble_id, bubble_ex, bubble_wb}, e.ctl);
         check({e.name, ".err"}, {7'b0, data_err}, {7'b0, e.err});
         if (e.chk_cnt) begin
            check({e.name, ".cycle_cnt"},   {4'b0, cycle_cnt},   {4'b0, e.cyc});
            check({e.name, ".instret_cnt"}, {4'b0, instret_cnt}, {4'b0, e.ins});
            check({e.name, ".stall_cnt"},   {4'b0, stall_cnt},   {4'b0, e.stl});
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      load_use_hazard = 1'b0;
      branch_taken    = 1'b0;
      instr_rvalid    = 1'b1;
      ex_busy         = 1'b0;
      data_req        = 1'b0;
      data_gnt        = 1'b0;
      data_rvalid     = 1'b0;
      retire          = 1'b0;
      cnt_clr         = 1'b0;
   endtask

   task automatic expect_ctl(input string name, input logic [7:0] ctl, input logic err);
      exp_t e;
      e.name = name; e.ctl = ctl; e.err = err; e.chk_cnt = 1'b0;
      e.cyc = '0; e.ins = '0; e.stl = '0;
      sb_q.push_back(e);
   endtask

   task automatic expect_cnt(input string name, input logic [7:0] ctl, input logic err,
                             input logic [3:0] cyc, input logic [3:0] ins, input logic [3:0] stl);
      exp_t e;
      e.name = name; e.ctl = ctl; e.err = err; e.chk_cnt = 1'b1;
      e.cyc = cyc; e.ins = ins; e.stl = stl;
      sb_q.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      next_cycle();
      expect_cnt("reset", C_NONE, 1'b0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Load granted immediately, response three cycles later.
      next_cycle(); data_req = 1; data_gnt = 1;    expect_ctl("ld_c0", C_MEM, 0);
      next_cycle(); data_req = 1;                  expect_ctl("ld_c1", C_MEM, 0);
      next_cycle(); data_req = 1;                  expect_ctl("ld_c2", C_MEM, 0);
      next_cycle(); data_req = 1; data_rvalid = 1; expect_ctl("ld_c3", C_NONE, 0);
      next_cycle();                                expect_ctl("ld_c4", C_NONE, 0);

      // Late grant; rvalid coinciding with gnt must be ignored.
      next_cycle(); data_req = 1;                               expect_ctl("st_nogn", C_MEM, 0);
      next_cycle(); data_req = 1; data_gnt = 1; data_rvalid = 1; expect_ctl("st_gn_rv", C_MEM, 0);
      next_cycle(); data_req = 1; data_rvalid = 1;              expect_ctl("st_rv", C_NONE, 0);
      next_cycle();                                             expect_ctl("st_idle", C_NONE, 0);

      // Priority rows.
      next_cycle(); load_use_hazard = 1; branch_taken = 1;  expect_ctl("lu_br", C_BR, 0);
      next_cycle(); load_use_hazard = 1;                    expect_ctl("lu", C_LU, 0);
      next_cycle(); load_use_hazard = 1; instr_rvalid = 0;  expect_ctl("lu_if", C_LU, 0);
      next_cycle(); branch_taken = 1; instr_rvalid = 0;     expect_ctl("br_if", C_BR, 0);
      next_cycle(); ex_busy = 1; branch_taken = 1; load_use_hazard = 1; expect_ctl("ex_br_lu", C_EX, 0);
      next_cycle(); data_req = 1; data_gnt = 1; ex_busy = 1; expect_ctl("mem_ex", C_MEM, 0);
      next_cycle(); data_rvalid = 1; ex_busy = 1;           expect_ctl("rv_ex", C_EX, 0);

      // Multi-cycle EX with a pending branch: five busy cycles, then the branch once.
      for (int i = 0; i < 5; i++) begin
         next_cycle(); ex_busy = 1; branch_taken = 1; expect_ctl($sformatf("exbusy_%0d", i), C_EX, 0);
      end
      next_cycle(); branch_taken = 1; expect_ctl("ex_br_done", C_BR, 0);
      next_cycle();                   expect_ctl("ex_after", C_NONE, 0);

      // Fetch wait counted by stall_cnt.
      next_cycle(); cnt_clr = 1;                           expect_ctl("clr_a", C_NONE, 0);
      next_cycle(); instr_rvalid = 0; expect_cnt("ifw_0", C_IF, 0, 4'd0, 4'd0, 4'd0);
      next_cycle(); instr_rvalid = 0; expect_cnt("ifw_1", C_IF, 0, 4'd1, 4'd0, 4'd1);
      next_cycle(); instr_rvalid = 0; expect_cnt("ifw_2", C_IF, 0, 4'd2, 4'd0, 4'd2);
      next_cycle();                   expect_cnt("ifw_end", C_NONE, 0, 4'd3, 4'd0, 4'd3);

      // Counter wrap at 2^4 after 20 retiring cycles, then clear.
      next_cycle(); cnt_clr = 1; expect_ctl("clr_b", C_NONE, 0);
      for (int k = 1; k <= 20; k++) begin
         logic [3:0] v;
         v = 4'((k - 1) % 16);
         next_cycle(); retire = 1; expect_cnt($sformatf("ret_%0d", k), C_NONE, 0, v, v, 4'd0);
      end
      next_cycle(); cnt_clr = 1; expect_cnt("wrapped", C_NONE, 0, 4'd4, 4'd4, 4'd0);
      next_cycle();              expect_cnt("cleared", C_NONE, 0, 4'd0, 4'd0, 4'd0);

      // Grant never arrives: four waiting cycles, then the sticky trap.
      next_cycle(); data_req = 1; expect_ctl("to_req", C_MEM, 0);
      for (int i = 1; i <= 4; i++) begin
         next_cycle(); data_req = 1; expect_ctl($sformatf("to_wait_%0d", i), C_MEM, 0);
      end
      next_cycle(); data_req = 1; expect_ctl("to_err", C_MEM, 1);
      next_cycle(); data_gnt = 1; data_rvalid = 1; expect_ctl("err_sticky_0", C_MEM, 1);
      next_cycle();               expect_ctl("err_sticky_1", C_MEM, 1);
      next_cycle(); rst_n = 1'b0; expect_cnt("err_reset", C_NONE, 0, 4'd0, 4'd0, 4'd0);
      next_cycle();               expect_cnt("err_reset_hold", C_NONE, 0, 4'd0, 4'd0, 4'd0);

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/panda_pipeline_ctrl.md
Name: panda_pipeline_ctrl

Overview:
Parametrised successor to the single-signal hazard controller in the Panda core. It arbitrates every stall, bubble and flush request in the 5-stage pipeline: load-use, taken branch/jump, instruction-fetch wait, multi-cycle EX unit, and variable-latency data memory with a req/gnt/rvalid handshake. It owns the data-transaction FSM with timeout and the performance counters. It sits beside the stage instances in panda_core and drives their stall/bubble/flush inputs.

Parameters:
CNT_W, 32, width of each performance counter (1..64)
TIMEOUT, 255, max cycles spent in WAIT_GNT+WAIT_RVALID before the bus-error trap (>=1)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
load_use_hazard_i  input  1  ID instruction needs the result of a load currently in EX
branch_taken_i  input  1  EX redirect (taken branch or jump)
instr_rvalid_i  input  1  fetch data valid this cycle
ex_busy_i  input  1  multi-cycle EX unit not done
data_req_i  input  1  MEM stage holds a load/store
data_gnt_i  input  1  data bus accepted the request
data_rvalid_i  input  1  data bus response (loads and stores)
retire_i  input  1  valid instruction in WB this cycle
cnt_clr_i  input  1  synchronous clear of all counters
stall_if_o  output  1  hold PC and IF/ID
stall_id_o  output  1  hold ID/EX
stall_ex_o  output  1  hold EX/MEM
stall_mem_o  output  1  hold MEM/WB inputs
bubble_if_o  output  1  load NOP into IF/ID
bubble_id_o  output  1  load NOP into ID/EX
bubble_ex_o  output  1  load NOP into EX/MEM
bubble_wb_o  output  1  load NOP into MEM/WB
data_err_o  output  1  sticky bus-timeout trap
cycle_cnt_o  output  CNT_W  cycles since reset/clear
instret_cnt_o  output  CNT_W  retired instructions
stall_cnt_o  output  CNT_W  cycles with stall_if_o=1

Behaviour:
- Reset: FSM=IDLE, timeout counter=0, data_err_o=0, all counters=0. Control outputs are combinational in inputs and FSM state.
- Data FSM states: IDLE, WAIT_GNT, WAIT_RVALID, ERROR.
  - IDLE: req&gnt -> WAIT_RVALID; req&!gnt -> WAIT_GNT.
  - WAIT_GNT: gnt -> WAIT_RVALID.
  - WAIT_RVALID: rvalid -> IDLE.
  - ERROR: terminal until reset.
- Timeout counter: cleared on entering IDLE; increments each cycle in WAIT_GNT or WAIT_RVALID. When it reaches TIMEOUT without progress -> ERROR.
- rvalid in the same cycle as gnt is illegal and is ignored.
- mem_stall = (IDLE&req) | WAIT_GNT | (WAIT_RVALID&!rvalid) | ERROR. The rvalid cycle releases the stall; the load data is captured that cycle.
- data_err_o=1 in ERROR. In ERROR, mem_stall stays 1 forever, so the core halts.
- Priority, highest first. Only the winning row drives outputs; all others are 0.
  1. mem_stall: stall_if/id/ex/mem=1, bubble_wb=1.
  2. ex_busy_i: stall_if/id/ex=1, bubble_ex=1.
  3. branch_taken_i: bubble_if=1, bubble_id=1, stall_if=0 so the PC loads the target. This row overrides load-use and fetch wait.
  4. load_use_hazard_i: stall_if=1, bubble_id=1.
  5. !instr_rvalid_i: stall_if=1, bubble_if=1.
  6. Otherwise all 0.
- A branch raised during mem_stall or ex_busy is held in EX and takes effect on the first unstalled cycle. It is never lost or taken twice.
- Counters:
  - cycle_cnt increments every cycle, including ERROR.
  - instret_cnt increments on retire_i.
  - stall_cnt increments when stall_if_o=1.
  - All counters wrap modulo 2^CNT_W.
  - cnt_clr_i has priority over increment; the counters read 0 the next cycle.
- Reset asserted mid-transaction: FSM returns to IDLE asynchronously, the trap clears, and the outstanding response is discarded by the bus side.

Test Plan:
- Load with gnt=1 at cycle 0 and rvalid=1 at cycle 3 -> stall_*=1, bubble_wb=1 for cycles 0..2; all 0 at cycle 3; FSM back to IDLE at cycle 4.
- req held with gnt=0 and TIMEOUT=4 -> ERROR after 4 waiting cycles; data_err_o=1 and all stalls=1 until rst_ni=0, after which all outputs=0.
- load_use_hazard_i=1 and branch_taken_i=1 together -> bubble_if=1, bubble_id=1, stall_if=0.
- ex_busy_i=1 for 5 cycles with branch_taken_i=1 throughout -> 5 cycles stall_if/id/ex=1 with bubble_ex=1, then one cycle of bubble_if=bubble_id=1.
- CNT_W=4, 20 cycles with retire_i=1 -> cycle_cnt=4 and instret_cnt=4 (wrapped); cnt_clr_i pulse -> both 0 next cycle.
- instr_rvalid_i=0 for 3 cycles -> stall_if=bubble_if=1 for 3 cycles and stall_cnt=3.
